pipe_skid_stage: RTL and testbench

// - Parametrised, handshaked pipeline-stage register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
// - Carries a control bundle and a data bundle with valid/ready flow control, stall back-pressure and flush.
// - A flush injects a bubble whose control bits are all zero.
// - An optional 2-entry skid buffer registers in_ready, so the ready path is not combinational across stages.

---
 rtl/pipe_skid_stage.sv | 120 ++++++++++++
 tb/tb_pipe_skid_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// Handshaked pipeline-stage register with flush-to-bubble and an
// optional 2-entry skid buffer that keeps in_ready off the combinational path.
module pipe_skid_stage #(
    parameter int unsigned DATA_W   = 128,
    parameter int unsigned CTRL_W   = 12,
    parameter int unsigned SKID     = 1,
    parameter int unsigned CLR_DATA = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              push;
    logic              pop;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;
    assign occ       = state_q;

    // Skid mode derives ready from state only; single-entry mode looks at out_ready.
    assign in_ready = (SKID != 0) ? (state_q != ST_SKID)
                                  : (~out_valid | out_ready);

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Next-state and register-load selection; flush overrides any handshake.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            if (CLR_DATA != 0) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d     = ST_FULL;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                ST_FULL: begin
                    if (push && pop) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (pop) begin
                        state_d     = ST_EMPTY;
                        main_ctrl_d = '0;
                    end else if (push) begin
                        state_d     = ST_SKID;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end
                end
                ST_SKID: begin
                    if (pop) begin
                        state_d     = ST_FULL;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_ctrl_d = '0;
                end
            endcase
        end
    end

    // State and bundle registers; data clears on reset only when CLR_DATA is set.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
            if (CLR_DATA != 0) begin
                main_data_q <= '0;
                skid_data_q <= '0;
            end
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: a skid/clear-data instance and a
// single-entry instance, each checked against a queue scoreboard.
module tb_pipe_skid_stage;

    typedef struct packed {
        logic [11:0]  c;
        logic [127:0] d;
    } ent_t;

    logic         clk;
    logic         reset;

    logic         a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [11:0]  a_in_ctrl, a_out_ctrl;
    logic [127:0] a_in_data, a_out_data;
    logic [1:0]   a_occ;

    logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [11:0]  b_in_ctrl, b_out_ctrl;
    logic [127:0] b_in_data, b_out_data;
    logic [1:0]   b_occ;

    ent_t sbq[$];
    ent_t bq[$];
    int   total;
    int   pass;

    pipe_skid_stage #(.DATA_W(128), .CTRL_W(12), .SKID(1), .CLR_DATA(1)) u_a (
        .clk(clk), .reset(reset), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_ctrl(a_in_ctrl), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_ctrl(a_out_ctrl), .out_data(a_out_data), .occ(a_occ)
    );

    pipe_skid_stage #(.DATA_W(128), .CTRL_W(12), .SKID(0), .CLR_DATA(0)) u_b (
        .clk(clk), .reset(reset), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_ctrl(b_in_ctrl), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_ctrl(b_out_ctrl), .out_data(b_out_data), .occ(b_occ)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive_a(input logic v, input logic [11:0] c, input logic r);
        a_in_valid  = v;
        a_in_ctrl   = c;
        a_in_data   = rnd128();
        a_out_ready = r;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a_flush = 0; a_in_valid = 0; a_out_ready = 0;
        a_in_ctrl = '0; a_in_data = '0;
        b_flush = 0; b_in_valid = 0; b_out_ready = 0;
        b_in_ctrl = '0; b_in_data = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        sbq.delete();
        bq.delete();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (a_out_valid !== 1'b0) $display("FAIL rst_valid got %0b exp 0", a_out_valid); else pass++;
        total++; if (a_out_ctrl !== 12'h0) $display("FAIL rst_ctrl got %h exp 0", a_out_ctrl); else pass++;
        total++; if (a_occ !== 2'd0) $display("FAIL rst_occ got %0d exp 0", a_occ); else pass++;
        total++; if (a_in_ready !== 1'b1) $display("FAIL rst_ready got %0b exp 1", a_in_ready); else pass++;
        total++; if (a_out_data !== 128'h0) $display("FAIL rst_data got %h exp 0", a_out_data); else pass++;
        total++; if (b_out_valid !== 1'b0) $display("FAIL rst_b_valid got %0b exp 0", b_out_valid); else pass++;
        total++; if (b_occ !== 2'd0) $display("FAIL rst_b_occ got %0d exp 0", b_occ); else pass++;
        total++; if (b_in_ready !== 1'b1) $display("FAIL rst_b_ready got %0b exp 1", b_in_ready); else pass++;
    endtask

    task automatic test_streaming();
        ent_t e;
        for (int i = 1; i <= 8; i++) begin
            drive_a(1'b1, 12'(i), 1'b1);
            sbq.push_back({a_in_ctrl, a_in_data});
            @(negedge clk);
            e = sbq.pop_front();
            total++; if (a_out_valid !== 1'b1) $display("FAIL t1_valid[%0d] got %0b exp 1", i, a_out_valid); else pass++;
            total++; if (a_out_ctrl !== e.c) $display("FAIL t1_ctrl[%0d] got %h exp %h", i, a_out_ctrl, e.c); else pass++;
            total++; if (a_out_data !== e.d) $display("FAIL t1_data[%0d] got %h exp %h", i, a_out_data, e.d); else pass++;
            total++; if (a_in_ready !== 1'b1) $display("FAIL t1_ready[%0d] got %0b exp 1", i, a_in_ready); else pass++;
        end
        a_in_valid = 1'b0;
        @(negedge clk);
        total++; if (a_out_valid !== 1'b0) $display("FAIL t1_drain_valid got %0b exp 0", a_out_valid); else pass++;
        total++; if (a_out_ctrl !== 12'h0) $display("FAIL t1_bubble_ctrl got %h exp 0", a_out_ctrl); else pass++;
        total++; if (a_occ !== 2'd0) $display("FAIL t1_drain_occ got %0d exp 0", a_occ); else pass++;
    endtask

    task automatic test_stall_skid();
        ent_t c_ent;
        drive_a(1'b1, 12'hA01, 1'b0);
        sbq.push_back({a_in_ctrl, a_in_data});
        @(negedge clk);
        total++; if (a_occ !== 2'd1) $display("FAIL t2_occA got %0d exp 1", a_occ); else pass++;
        total++; if (a_in_ready !== 1'b1) $display("FAIL t2_readyA got %0b exp 1", a_in_ready); else pass++;
        drive_a(1'b1, 12'hB02, 1'b0);
        sbq.push_back({a_in_ctrl, a_in_data});
        @(negedge clk);
        total++; if (a_occ !== 2'd2) $display("FAIL t2_occB got %0d exp 2", a_occ); else pass++;
        total++; if (a_in_ready !== 1'b0) $display("FAIL t2_readyB got %0b exp 0", a_in_ready); else pass++;
        drive_a(1'b1, 12'hC03, 1'b0);
        c_ent = {a_in_ctrl, a_in_data};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (a_occ !== 2'd2) $display("FAIL t2_hold_occ[%0d] got %0d exp 2", k, a_occ); else pass++;
            total++; if (a_in_ready !== 1'b0) $display("FAIL t2_hold_ready[%0d] got %0b exp 0", k, a_in_ready); else pass++;
            total++; if ({a_out_ctrl, a_out_data} !== sbq[0]) $display("FAIL t2_stable[%0d] got %h exp %h", k, {a_out_ctrl, a_out_data}, sbq[0]); else pass++;
        end
        a_out_ready = 1'b1;
        @(negedge clk);
        void'(sbq.pop_front());
        total++; if ({a_out_ctrl, a_out_data} !== sbq[0]) $display("FAIL t2_outB got %h exp %h", {a_out_ctrl, a_out_data}, sbq[0]); else pass++;
        total++; if (a_occ !== 2'd1) $display("FAIL t2_occ_rel got %0d exp 1", a_occ); else pass++;
        total++; if (a_in_ready !== 1'b1) $display("FAIL t2_ready_rel got %0b exp 1", a_in_ready); else pass++;
        sbq.push_back(c_ent);
        @(negedge clk);
        void'(sbq.pop_front());
        a_in_valid = 1'b0;
        total++; if ({a_out_ctrl, a_out_data} !== sbq[0]) $display("FAIL t2_outC got %h exp %h", {a_out_ctrl, a_out_data}, sbq[0]); else pass++;
        total++; if (a_out_valid !== 1'b1) $display("FAIL t2_validC got %0b exp 1", a_out_valid); else pass++;
        @(negedge clk);
        void'(sbq.pop_front());
        total++; if (a_out_valid !== 1'b0) $display("FAIL t2_end_valid got %0b exp 0", a_out_valid); else pass++;
        total++; if (a_out_ctrl !== 12'h0) $display("FAIL t2_end_ctrl got %h exp 0", a_out_ctrl); else pass++;
    endtask

    task automatic fill_skid();
        drive_a(1'b1, 12'h111, 1'b0);
        @(negedge clk);
        drive_a(1'b1, 12'h222, 1'b0);
        @(negedge clk);
        total++; if (a_occ !== 2'd2) $display("FAIL fill_occ got %0d exp 2", a_occ); else pass++;
    endtask

    task automatic test_flush();
        fill_skid();
        drive_a(1'b1, 12'hDDD, 1'b0);
        a_flush = 1'b1;
        @(negedge clk);
        a_flush = 1'b0;
        total++; if (a_out_valid !== 1'b0) $display("FAIL t3_valid got %0b exp 0", a_out_valid); else pass++;
        total++; if (a_out_ctrl !== 12'h0) $display("FAIL t3_ctrl got %h exp 0", a_out_ctrl); else pass++;
        total++; if (a_occ !== 2'd0) $display("FAIL t3_occ got %0d exp 0", a_occ); else pass++;
        total++; if (a_in_ready !== 1'b1) $display("FAIL t3_ready got %0b exp 1", a_in_ready); else pass++;
        total++; if (a_out_data !== 128'h0) $display("FAIL t3_data got %h exp 0", a_out_data); else pass++;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++; if (a_out_valid !== 1'b0) $display("FAIL t3_ghost[%0d] got %0b exp 0", k, a_out_valid); else pass++;
        end
    endtask

    task automatic test_reset_stall();
        fill_skid();
        a_in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (a_out_valid !== 1'b0) $display("FAIL t4_valid got %0b exp 0", a_out_valid); else pass++;
        total++; if (a_out_ctrl !== 12'h0) $display("FAIL t4_ctrl got %h exp 0", a_out_ctrl); else pass++;
        total++; if (a_occ !== 2'd0) $display("FAIL t4_occ got %0d exp 0", a_occ); else pass++;
        total++; if (a_out_data !== 128'h0) $display("FAIL t4_data got %h exp 0", a_out_data); else pass++;
        total++; if (a_in_ready !== 1'b1) $display("FAIL t4_ready got %0b exp 1", a_in_ready); else pass++;
        a_out_ready = 1'b1;
        @(negedge clk);
        total++; if (a_out_valid !== 1'b0) $display("FAIL t4_ghost got %0b exp 0", a_out_valid); else pass++;
    endtask

    task automatic test_push_pop_full();
        ent_t e;
        drive_a(1'b1, 12'h0A5, 1'b0);
        sbq.push_back({a_in_ctrl, a_in_data});
        @(negedge clk);
        drive_a(1'b1, 12'h05B, 1'b1);
        sbq.push_back({a_in_ctrl, a_in_data});
        void'(sbq.pop_front());
        @(negedge clk);
        a_in_valid = 1'b0;
        e = sbq[0];
        total++; if (a_out_valid !== 1'b1) $display("FAIL t6_valid got %0b exp 1", a_out_valid); else pass++;
        total++; if ({a_out_ctrl, a_out_data} !== e) $display("FAIL t6_outB got %h exp %h", {a_out_ctrl, a_out_data}, e); else pass++;
        total++; if (a_occ !== 2'd1) $display("FAIL t6_occ got %0d exp 1", a_occ); else pass++;
        @(negedge clk);
        void'(sbq.pop_front());
        total++; if (a_out_valid !== 1'b0) $display("FAIL t6_drain got %0b exp 0", a_out_valid); else pass++;
    endtask

    task automatic test_skid0_random();
        logic exp_rdy;
        for (int i = 0; i < 10000; i++) begin
            total++; if (int'(b_occ) !== bq.size()) $display("FAIL t5_occ[%0d] got %0d exp %0d", i, b_occ, bq.size()); else pass++;
            total++; if (b_occ > 2'd1) $display("FAIL t5_occmax[%0d] got %0d exp <=1", i, b_occ); else pass++;
            b_in_valid  = 1'($urandom_range(0, 1));
            b_out_ready = 1'($urandom_range(0, 1));
            b_in_ctrl   = 12'($urandom);
            b_in_data   = rnd128();
            #1;
            exp_rdy = (bq.size() == 0) | b_out_ready;
            total++; if (b_in_ready !== exp_rdy) $display("FAIL t5_ready[%0d] got %0b exp %0b", i, b_in_ready, exp_rdy); else pass++;
            if (b_out_valid) begin
                total++;
                if (bq.size() == 0) $display("FAIL t5_extra[%0d] got %h exp none", i, {b_out_ctrl, b_out_data});
                else if ({b_out_ctrl, b_out_data} !== bq[0]) $display("FAIL t5_out[%0d] got %h exp %h", i, {b_out_ctrl, b_out_data}, bq[0]);
                else pass++;
                if (b_out_ready && bq.size() != 0) void'(bq.pop_front());
            end else begin
                total++; if (b_out_ctrl !== 12'h0) $display("FAIL t5_bubble[%0d] got %h exp 0", i, b_out_ctrl); else pass++;
            end
            if (b_in_valid && b_in_ready) bq.push_back({b_in_ctrl, b_in_data});
            @(negedge clk);
        end
        b_in_valid = 1'b0;
        b_out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++; if (b_out_valid !== 1'b0) $display("FAIL t5_drain got %0b exp 0", b_out_valid); else pass++;
    endtask

    initial begin
        clk   = 1'b0;
        total = 0;
        pass  = 0;
        test_reset();
        test_streaming();
        test_stall_skid();
        test_flush();
        test_reset_stall();
        test_push_pop_full();
        test_skid0_random();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
